// File: rtl/pwm_capture_pkg.sv
// Shared state encoding and width helpers for the PWM capture block.
// No logic; constants and pure functions only.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MEAS  = 2'd1,
      ST_STUCK = 2'd2
   } cap_state_t;

   // value width: must hold SCALE itself (100 % duty)
   function automatic int val_w(input int scale);
      return $clog2(scale) + 1;
   endfunction

   // period width: must hold TIMEOUT itself (longest measurable period)
   function automatic int per_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// PWM line in, measurement results out; master drives the line, slave measures it.
// No backpressure: results are strobed once and then held.
interface pwm_capture_if
   import pwm_capture_pkg::*;
#(
   parameter int SCALE   = 256,
   parameter int TIMEOUT = 2 * SCALE
);
   localparam int W  = val_w(SCALE);
   localparam int PW = per_w(TIMEOUT);

   logic          pwm_in;
   logic [W-1:0]  value;
   logic [PW-1:0] period;
   logic          valid;
   logic          stuck;

   modport master (output pwm_in, input value, period, valid, stuck);
   modport slave  (input pwm_in, output value, period, valid, stuck);
endinterface

// File: rtl/pwm_sync_edge.sv
// Synchronises an async line through SYNC_STAGES flops and flags rise/fall.
// Latency SYNC_STAGES cycles to s_in; edges are combinational from s_in and its delay.
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic s_in,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_in_d;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         sync_q <= '0;
         s_in_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         s_in_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s_in = sync_q[SYNC_STAGES-1];
   assign rise = s_in & ~s_in_d;
   assign fall = ~s_in & s_in_d;
endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an async PWM line; reports stuck lines via timeout.
// Registered one-cycle valid strobe per period; no backpressure, outputs hold between strobes.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int SCALE       = 256,
   parameter int TIMEOUT     = 2 * SCALE,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         n_rst,
   pwm_capture_if.slave bus
);
   localparam int W  = val_w(SCALE);
   localparam int PW = per_w(TIMEOUT);

   localparam logic [W-1:0]  HI_MAX    = '1;
   localparam logic [PW-1:0] PER_MAX   = '1;
   localparam logic [W-1:0]  SCALE_V   = W'(SCALE);
   localparam logic [PW-1:0] TIMEOUT_V = PW'(TIMEOUT);

   logic          s_in;
   logic          rise;
   logic          fall;
   logic          timeout;
   logic [PW-1:0] per_cnt;
   logic [W-1:0]  hi_cnt;
   cap_state_t    state;

   logic [W-1:0]  value_q;
   logic [PW-1:0] period_q;
   logic          valid_q;
   logic          stuck_q;

   pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (bus.pwm_in),
      .s_in     (s_in),
      .rise     (rise),
      .fall     (fall)
   );

   // a rise in the timeout cycle still closes a valid period
   assign timeout = (per_cnt == TIMEOUT_V) && !rise;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         per_cnt <= PW'(1);
         hi_cnt  <= W'(1);
      end else begin
         if (state == ST_STUCK && fall)
            per_cnt <= PW'(1);
         else if (per_cnt != PER_MAX)
            per_cnt <= per_cnt + PW'(1);
         if (s_in && hi_cnt != HI_MAX)
            hi_cnt <= hi_cnt + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= ST_IDLE;
         value_q  <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            ST_IDLE, ST_MEAS: begin
               if (rise) begin
                  // the first rise after IDLE only opens a period
                  if (state == ST_MEAS) begin
                     value_q  <= hi_cnt;
                     period_q <= per_cnt;
                     stuck_q  <= 1'b0;
                     valid_q  <= 1'b1;
                  end
                  state <= ST_MEAS;
               end else if (timeout) begin
                  value_q  <= s_in ? SCALE_V : '0;
                  period_q <= '0;
                  stuck_q  <= 1'b1;
                  valid_q  <= 1'b1;
                  state    <= ST_STUCK;
               end
            end
            ST_STUCK: begin
               if (rise)
                  state <= ST_MEAS;
               else if (fall)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.value  = value_q;
   assign bus.period = period_q;
   assign bus.valid  = valid_q;
   assign bus.stuck  = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a behavioural PWM generator and manual pulses drive the line,
// expected reports are queued per scenario and matched against each valid strobe.
module tb_pwm_capture;
   logic clk;
   logic n_rst;

   pwm_capture_if #(.SCALE(256), .TIMEOUT(512)) bus ();

   pwm_capture #(.SCALE(256), .TIMEOUT(512), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   typedef struct {
      int     value;
      int     period;
      int     stuck;
      longint earliest;
   } exp_t;

   exp_t   sb[$];
   exp_t   mon_e;
   int     n_checks = 0;
   int     n_fail   = 0;
   longint cyc      = 0;
   int     gen_en   = 0;
   int     gen_val  = 0;
   int     gen_cnt  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int v, input int p, input int s, input longint e);
      sb.push_back('{v, p, s, e});
   endtask

   // one clock; the generator is a free-running 256-cycle counter compared against gen_val
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (gen_en != 0) begin
            gen_cnt    = (gen_cnt == 255) ? 0 : gen_cnt + 1;
            bus.pwm_in = (gen_cnt < gen_val);
         end
      end
   endtask

   task automatic gen_start(input int v);
      gen_en     = 1;
      gen_val    = v;
      gen_cnt    = 0;
      bus.pwm_in = (v > 0);
   endtask

   task automatic do_reset();
      gen_en     = 0;
      bus.pwm_in = 1'b0;
      n_rst      = 1'b0;
      tick(3);
      n_rst = 1'b1;
      tick(2);
   endtask

   always @(negedge clk) begin
      if (bus.valid) begin
         if (sb.size() == 0) begin
            chk("unexp_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("value", longint'(bus.value), longint'(mon_e.value));
            chk("period", longint'(bus.period), longint'(mon_e.period));
            chk("stuck", longint'(bus.stuck), longint'(mon_e.stuck));
            chk("too_early", (cyc >= mon_e.earliest) ? 1 : 0, 1);
         end
      end
   end

   initial begin
      longint s;
      int     gaps[6];

      n_rst      = 1'b0;
      bus.pwm_in = 1'b0;
      tick(3);
      chk("rst_value", longint'(bus.value), 0);
      chk("rst_period", longint'(bus.period), 0);
      chk("rst_valid", longint'(bus.valid), 0);
      chk("rst_stuck", longint'(bus.stuck), 0);
      n_rst = 1'b1;
      tick(2);

      // steady 25 % duty: a report on every rise after the first
      do_reset();
      gen_start(64);
      s = cyc;
      for (int k = 1; k <= 4; k++) push(64, 256, 0, s + 256 * k);
      tick(4 * 256 + 20);
      chk("drain_gen64", sb.size(), 0);

      // constant low: silent until the timeout, then one stuck report
      do_reset();
      gen_start(0);
      s = cyc;
      push(0, 0, 1, s + 500);
      tick(600);
      chk("drain_gen0", sb.size(), 0);

      // constant high: one stuck report at full scale, then silence
      do_reset();
      gen_start(256);
      s = cyc;
      push(256, 0, 1, s + 500);
      tick(700);
      chk("drain_gen256", sb.size(), 0);
      chk("stuck_level", longint'(bus.stuck), 1);
      chk("stuck_period", longint'(bus.period), 0);

      // leave stuck: switch to 50 % mid-period
      for (int i = 0; i < 300 && gen_cnt != 200; i++) tick(1);
      chk("gen_align", gen_cnt, 200);
      gen_val = 128;
      s = cyc;
      push(128, 256, 0, s + 256);
      push(128, 256, 0, s + 512);
      tick(100);
      chk("stuck_hold", longint'(bus.stuck), 1);
      tick(500);
      chk("drain_switch", sb.size(), 0);

      // single-cycle pulses: 512 is the longest measurable period, 513 times out
      do_reset();
      gaps = '{512, 512, 512, 513, 513, 20};
      for (int i = 0; i < 6; i++) begin
         s = cyc;
         if (gaps[i] == 512) push(1, 512, 0, s + 500);
         if (gaps[i] == 513) push(0, 0, 1, s + 500);
         bus.pwm_in = 1'b1;
         tick(1);
         bus.pwm_in = 1'b0;
         tick(gaps[i] - 1);
      end
      chk("drain_pulses", sb.size(), 0);

      // reset mid-period discards the partial measurement
      do_reset();
      gen_start(200);
      s = cyc;
      push(200, 256, 0, s + 256);
      push(200, 256, 0, s + 512);
      tick(2 * 256 + 100);
      chk("drain_pre_rst", sb.size(), 0);
      n_rst = 1'b0;
      tick(2);
      chk("mid_rst_value", longint'(bus.value), 0);
      chk("mid_rst_period", longint'(bus.period), 0);
      chk("mid_rst_valid", longint'(bus.valid), 0);
      chk("mid_rst_stuck", longint'(bus.stuck), 0);
      tick(118);
      n_rst = 1'b1;
      s = cyc;
      push(200, 256, 0, s + 36 + 256 - 5);
      tick(36 + 256 + 30);
      chk("drain_post_rst", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
